// File: rtl/imem_boot_loader_if.sv
// ============================================================================
// imem_boot_loader_if : byte-stream and instruction-memory write bundle
// Revision: 1.0
// ============================================================================
`default_nettype none

interface imem_boot_loader_if #(
   parameter int ADDR_W = 8
);
   logic [7:0]        s_data;
   logic              s_valid;
   logic              s_ready;
   logic              imem_we;
   logic [ADDR_W-1:0] imem_addr;
   logic [31:0]       imem_wdata;

   // master: byte source and memory sink; slave: the loader itself
   modport master (
      output s_data, s_valid,
      input  s_ready, imem_we, imem_addr, imem_wdata
   );
   modport slave (
      input  s_data, s_valid,
      output s_ready, imem_we, imem_addr, imem_wdata
   );
endinterface

`default_nettype wire

// File: rtl/imem_boot_loader.sv
// ============================================================================
// imem_boot_loader : loads a length/data/checksum byte frame into imem
// Revision: 1.0
// ============================================================================
`default_nettype none

module imem_boot_loader #(
   parameter int ADDR_W    = 8,
   parameter int MAX_WORDS = 256
) (
   input  wire logic             clk,
   input  wire logic             rst,
   input  wire logic             start,
   imem_boot_loader_if.slave     bus,
   output logic                  core_rst,
   output logic                  busy,
   output logic                  done,
   output logic                  err
);

   localparam logic [2:0] S_IDLE  = 3'd0;
   localparam logic [2:0] S_LEN0  = 3'd1;
   localparam logic [2:0] S_LEN1  = 3'd2;
   localparam logic [2:0] S_DATA  = 3'd3;
   localparam logic [2:0] S_WRITE = 3'd4;
   localparam logic [2:0] S_CSUM  = 3'd5;
   localparam logic [2:0] S_DONE  = 3'd6;
   localparam logic [2:0] S_ERR   = 3'd7;

   localparam logic [16:0] C_MAX_WORDS = 17'(MAX_WORDS);

   logic [2:0]      state_q, state_d;
   logic [15:0]     len_q, len_d;
   logic [ADDR_W:0] widx_q, widx_d;
   logic [1:0]      bcnt_q, bcnt_d;
   logic [31:0]     word_q, word_d;
   logic [7:0]      csum_q, csum_d;

   logic            w_ready;
   logic            w_accept;
   logic [15:0]     w_len_new;
   logic [ADDR_W:0] w_widx_inc;

   always_comb begin
      w_ready = (state_q == S_LEN0) || (state_q == S_LEN1) ||
                (state_q == S_DATA) || (state_q == S_CSUM);
   end

   assign w_accept   = w_ready && bus.s_valid;
   assign w_len_new  = {bus.s_data, len_q[7:0]};
   assign w_widx_inc = widx_q + 1'b1;

   always_comb begin
      state_d = state_q;
      len_d   = len_q;
      widx_d  = widx_q;
      bcnt_d  = bcnt_q;
      word_d  = word_q;
      csum_d  = csum_q;
      if (w_accept) begin
         csum_d = csum_q + bus.s_data;
      end
      case (state_q)
         S_IDLE, S_DONE, S_ERR: begin
            if (start) begin
               state_d = S_LEN0;
               csum_d  = '0;
            end
         end
         S_LEN0: begin
            if (w_accept) begin
               len_d[7:0] = bus.s_data;
               state_d    = S_LEN1;
            end
         end
         S_LEN1: begin
            if (w_accept) begin
               len_d[15:8] = bus.s_data;
               if ((w_len_new == 16'd0) || ({1'b0, w_len_new} > C_MAX_WORDS)) begin
                  state_d = S_ERR;
               end else begin
                  state_d = S_DATA;
                  widx_d  = '0;
                  bcnt_d  = '0;
               end
            end
         end
         S_DATA: begin
            if (w_accept) begin
               word_d[{bcnt_q, 3'b000} +: 8] = bus.s_data;
               bcnt_d = bcnt_q + 2'd1;
               if (bcnt_q == 2'd3) begin
                  state_d = S_WRITE;
               end
            end
         end
         S_WRITE: begin
            widx_d = w_widx_inc;
            // index is one bit wider than the address so N == 2**ADDR_W ends cleanly
            if (32'(w_widx_inc) == 32'(len_q)) begin
               state_d = S_CSUM;
            end else begin
               state_d = S_DATA;
            end
         end
         S_CSUM: begin
            if (w_accept) begin
               state_d = (bus.s_data == csum_q) ? S_DONE : S_ERR;
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q <= S_IDLE;
         len_q   <= '0;
         widx_q  <= '0;
         bcnt_q  <= '0;
         word_q  <= '0;
         csum_q  <= '0;
      end else begin
         state_q <= state_d;
         len_q   <= len_d;
         widx_q  <= widx_d;
         bcnt_q  <= bcnt_d;
         word_q  <= word_d;
         csum_q  <= csum_d;
      end
   end

   // every output is a pure decode of the state register
   assign bus.s_ready    = w_ready;
   assign bus.imem_we    = (state_q == S_WRITE);
   assign bus.imem_addr  = (state_q == S_WRITE) ? widx_q[ADDR_W-1:0] : '0;
   assign bus.imem_wdata = (state_q == S_WRITE) ? word_q : '0;
   assign core_rst       = (state_q == S_DONE);
   assign done           = (state_q == S_DONE);
   assign err            = (state_q == S_ERR);
   assign busy           = w_ready || (state_q == S_WRITE);

endmodule

`default_nettype wire

// File: doc/imem_boot_loader.md
Name: imem_boot_loader

Overview:
- Boot controller for the single-cycle RISC-V core.
- Receives a byte stream over a valid/ready handshake and assembles 32-bit little-endian words.
- Writes each word sequentially into instruction memory through a dedicated write port.
- Holds the core in reset until a complete image with a valid checksum has loaded. This replaces the simulation-only memory preload with a hardware load path.

Parameters:
- ADDR_W, 8, instruction-memory word-address width.
- MAX_WORDS, 256, largest accepted image size in words; must be <= 2**ADDR_W.

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  asynchronous, active-low reset.
- start  input  1  one-cycle pulse that begins a load. Sampled in IDLE, DONE and ERR; ignored in all other states.
- s_data  input  8  stream byte.
- s_valid  input  1  s_data is valid.
- s_ready  output  1  loader accepts a byte. A byte transfers when s_valid && s_ready.
- imem_we  output  1  instruction-memory write strobe, one cycle per word.
- imem_addr  output  ADDR_W  word address of the write.
- imem_wdata  output  32  word being written.
- core_rst  output  1  active-low reset to the core. 0 holds the core in reset.
- busy  output  1  load in progress.
- done  output  1  image loaded and verified.
- err  output  1  load failed.

Behaviour:
- Reset (async assert, sync deassert at clk edge):
  - State is IDLE.
  - All outputs are 0, including core_rst (core held) and s_ready.
  - Word index, byte counter, length register and checksum accumulator are cleared.
- Frame format:
  - LEN_LO, LEN_HI: N, 16-bit little-endian word count.
  - 4*N data bytes, little-endian within each word.
  - CSUM: 8-bit sum, mod 256, of every preceding byte including the length bytes.
- States and transitions:
  - IDLE: start -> LEN0.
  - LEN0: s_ready=1; on accept, latch low byte -> LEN1.
  - LEN1: s_ready=1; on accept, latch high byte.
    - If N==0 or N>MAX_WORDS -> ERR.
    - Otherwise -> DATA, with word index=0 and byte counter=0.
  - DATA: s_ready=1; each accepted byte goes into word byte lane [byte counter]. After the 4th byte -> WRITE.
  - WRITE: s_ready=0; imem_we=1 for exactly this cycle, with imem_addr=word index and imem_wdata=assembled word. Word index increments.
    - If the new index == N -> CSUM.
    - Otherwise -> DATA.
  - CSUM: s_ready=1; on accept, compare against the accumulator.
    - Equal -> DONE.
    - Unequal -> ERR.
  - DONE: done=1, core_rst=1. start -> LEN0, and core_rst returns to 0 on the same edge.
  - ERR: err=1, core_rst=0. start -> LEN0, and err clears.
- Output timing:
  - busy=1 in LEN0, LEN1, DATA, WRITE and CSUM.
  - All outputs are registered or decoded from the state register; none depends combinationally on s_valid or s_data.
  - imem_addr and imem_wdata are 0 outside WRITE.
- The accumulator adds each accepted byte mod 256. It is cleared on entry to LEN0.
- Minimum throughput is 5 cycles per word (4 accepts + 1 write). Gaps in s_valid stall without side effects.
- Memory is written before the checksum is verified. This is safe because the core remains in reset on any error.
- Reset asserted mid-load:
  - Immediate return to IDLE.
  - imem_we drops asynchronously.
  - No further writes.
  - core_rst=0.
- The word index is ADDR_W+1 bits wide, so N==2**ADDR_W terminates correctly without wrap.

Test Plan:
- Good image: start, then stream 02 00 93 00 50 00 63 00 00 00 48 ->
  - write addr0=0x00500093 and addr1=0x00000063, one imem_we cycle each;
  - done=1 and core_rst=1 one cycle after the CSUM byte is accepted.
- N=0: stream 00 00 -> ERR after LEN_HI accepted; err=1, no imem_we, core_rst=0.
- Oversize: with MAX_WORDS=256, stream 01 01 (N=257) -> ERR, no writes.
- Bad checksum: same image as the good case with final byte 47 -> both words written, then err=1, done=0, core_rst=0.
- Stall and backpressure:
  - insert random s_valid gaps -> identical writes;
  - s_ready=0 during WRITE;
  - a byte held valid through WRITE is accepted in the next DATA cycle, not lost or duplicated.
- Reset mid-DATA, then reload from DONE:
  - rst low after byte 5 -> IDLE, outputs 0, no writes.
  - Then a full good load followed by start in DONE -> core_rst falls on the next edge and the second image overwrites from addr 0.
